// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [6:0]  OP_JAL           = 7'b1101111;
   localparam logic [6:0]  OP_BRANCH        = 7'b1100011;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
   } iq_entry_t;

endpackage

// File: rtl/ifu_iq.sv
// Instruction queue: synchronous FIFO with flush, occupancy count and same-cycle enq/deq.
module ifu_iq
   import ifu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         i_flush,
   input  logic                         i_enq,
   input  iq_entry_t                    i_enq_data,
   input  logic                         i_deq,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_valid,
   output iq_entry_t                    o_head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   iq_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W-1:0] r_wr;
   logic [CNT_W-1:0] r_count;
   logic             r_valid;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_enq;
   logic             w_deq;

   assign w_enq       = i_enq && (r_count != CNT_W'(DEPTH));
   assign w_deq       = i_deq && r_valid;
   assign w_count_nxt = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);

   // Storage is cleared on reset so the head outputs read as zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[PTR_W'(i)] <= '0;
         end
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_enq) begin
            r_mem[r_wr] <= i_enq_data;
            r_wr        <= r_wr + PTR_W'(1);
         end
         if (w_deq) begin
            r_rd <= r_rd + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
      end
   end

   assign o_count = r_count;
   assign o_valid = r_valid;
   assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one icache request at a time and queues
// results for decode. Define IFU_BTFN_PRED_EN to enable backward-taken/forward-not-taken predecode.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned IQ_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        ic_require,
   output logic [31:0] ic_pc,
   input  logic        ic_valid,
   input  logic [31:0] ic_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_pred_taken
);

   localparam int unsigned CNT_W = $clog2(IQ_DEPTH + 1);

   fetch_state_t     r_state;
   fetch_state_t     w_state_nxt;
   logic [31:0]      r_pc;
   logic [31:0]      w_pc_nxt;
   logic [31:0]      w_next_pc;
   logic             r_kill;
   logic             w_kill_nxt;
   logic             w_req;
   logic             w_enq;
   logic             w_pred;
   logic             w_has_credit;
   logic [CNT_W-1:0] w_count;
   iq_entry_t        w_enq_data;
   iq_entry_t        w_head;

   // Credit uses the registered count only, so id_ready never reaches ic_require.
   assign w_has_credit = w_count < CNT_W'(IQ_DEPTH);

`ifdef IFU_BTFN_PRED_EN
   logic [31:0] w_imm_j;
   logic [31:0] w_imm_b;

   assign w_imm_j = {{11{ic_inst[31]}}, ic_inst[31], ic_inst[19:12], ic_inst[20], ic_inst[30:21], 1'b0};
   assign w_imm_b = {{19{ic_inst[31]}}, ic_inst[31], ic_inst[7], ic_inst[30:25], ic_inst[11:8], 1'b0};

   // JAL and backward branches are predicted taken.
   always_comb begin
      w_pred    = 1'b0;
      w_next_pc = r_pc + 32'd4;
      if (ic_inst[6:0] == OP_JAL) begin
         w_pred    = 1'b1;
         w_next_pc = r_pc + w_imm_j;
      end else if ((ic_inst[6:0] == OP_BRANCH) && ic_inst[31]) begin
         w_pred    = 1'b1;
         w_next_pc = r_pc + w_imm_b;
      end
   end
`else
   assign w_pred    = 1'b0;
   assign w_next_pc = r_pc + 32'd4;
`endif

   assign w_enq_data = '{pc: r_pc, inst: ic_inst, pred: w_pred};

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_kill_nxt  = r_kill;
      w_req       = 1'b0;
      w_enq       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!reset && w_has_credit && !redirect_valid) begin
               w_req       = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (ic_valid) begin
               w_state_nxt = IDLE;
               w_kill_nxt  = 1'b0;
               if (!r_kill && !redirect_valid) begin
                  w_enq    = 1'b1;
                  w_pc_nxt = w_next_pc;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Redirect wins; an outstanding response is marked stale until it returns.
      if (redirect_valid) begin
         w_pc_nxt = redirect_pc;
         if ((r_state == WAIT) && !ic_valid) begin
            w_kill_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_kill  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_kill  <= w_kill_nxt;
      end
   end

   ifu_iq #(
      .DEPTH (IQ_DEPTH)
   ) u_iq (
      .clock      (clock),
      .reset      (reset),
      .i_flush    (redirect_valid),
      .i_enq      (w_enq),
      .i_enq_data (w_enq_data),
      .i_deq      (id_ready),
      .o_count    (w_count),
      .o_valid    (id_valid),
      .o_head     (w_head)
   );

   assign ic_require    = w_req;
   assign ic_pc         = r_pc;
   assign id_pc         = w_head.pc;
   assign id_inst       = w_head.inst;
   assign id_pred_taken = w_head.pred;

endmodule
